// File: rtl/prio_rr_arbiter.sv
// Four-requester arbiter with fixed-priority or round-robin selection.
// A grant is registered, held while the owner keeps requesting, and
// forcibly removed after HOLD_MAX consecutive cycles (0 = no limit).
// Every release is followed by one dead cycle before the next grant.
module prio_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [2:0] gnt_code,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    owner;
    logic [1:0]    owner_next;
    logic [1:0]    last;
    logic [1:0]    last_next;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_next;
    logic          timeout_next;

    logic [1:0]    winner;
    logic          found;
    logic [1:0]    probe;
    logic          at_limit;

    // Pick the arbitration winner. Fixed mode takes the highest set index.
    // Round-robin searches L-1, L-2, ..., L; scanning from the far end
    // means the nearest candidate to L-1 is written last and wins.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        probe  = 2'd0;
        if (!mode) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    winner = 2'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 4; k >= 1; k--) begin
                probe = last - 2'(k);
                if (req[probe]) begin
                    winner = probe;
                    found  = 1'b1;
                end
            end
        end
    end

    // The hold limit only applies when HOLD_MAX is nonzero; HOLD_MAX is
    // expected to fit in CW bits so the counter can actually reach it.
    always_comb begin
        at_limit = (HOLD_MAX != 0) && (32'(hold_cnt) == 32'(HOLD_MAX));
    end

    // Next-state logic: arbitrate from IDLE, release or extend from GRANT.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        last_next     = last;
        hold_cnt_next = hold_cnt;
        timeout_next  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next    = GRANT;
                    owner_next    = winner;
                    last_next     = winner;
                    hold_cnt_next = CW'(1);
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else if (at_limit) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    timeout_next  = 1'b1;
                end else if (hold_cnt != {CW{1'b1}}) begin
                    hold_cnt_next = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // State register plus registered outputs derived from the next state,
    // so grant/gnt_code/busy/timeout all change together on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd0;
            hold_cnt <= '0;
            grant    <= 4'd0;
            gnt_code <= 3'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            last     <= last_next;
            hold_cnt <= hold_cnt_next;
            timeout  <= timeout_next;
            if (state_next == GRANT) begin
                grant    <= 4'b0001 << owner_next;
                gnt_code <= 3'(owner_next) + 3'd1;
                busy     <= 1'b1;
            end else begin
                grant    <= 4'd0;
                gnt_code <= 3'd0;
                busy     <= 1'b0;
            end
        end
    end

endmodule
